// File: rtl/unidade_controle_variavel.sv
// unidade_controle_variavel: variable-length SAP-1 control sequencer.
// Decodes the extended instruction set and ends each instruction in its last
// needed T-state. It also counts retired instructions and latches HLT.
// Optional single-step mode is compiled in with UC_SINGLE_STEP_EN.
module unidade_controle_variavel #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic            CLK,
  input  logic            CLR_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            Z,
  input  logic            C,
  input  logic            RUN,
  input  logic            STEP,
  output logic            Cp,
  output logic            Ep,
  output logic            Ej,
  output logic            Eu,
  output logic            Add,
  output logic            Sub,
  output logic            AndOp,
  output logic            OrOp,
  output logic            XorOp,
  output logic            NotOp,
  output logic            La,
  output logic            Ea,
  output logic            Lb,
  output logic            Lm,
  output logic            CE,
  output logic            We,
  output logic            L1,
  output logic            Ei,
  output logic            L0,
  output logic            Lf,
  output logic [2:0]      t_state,
  output logic            Hlt,
  output logic            instr_done,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h4,
    OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7, OP_XOR = 4'h8,
    OP_NOT = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB, OP_JC  = 4'hC,
    OP_OUT = 4'hE, OP_HLT = 4'hF
  } op_t;

  localparam int unsigned OW = (OPW > 4) ? OPW : 4;

  state_t          state_q, state_d;
  logic            hlt_q, hlt_d;
  logic [CNTW-1:0] retired_q, retired_d;
  logic [OW-1:0]   op_ext;
  logic [3:0]      op;
  logic            is_alu;
  logic            active;
  logic            done;

  // A nonzero upper opcode field does not match any listed code, so it decodes as NOP.
  assign op_ext = OW'(opcode);
  assign op     = ((op_ext >> 4) == '0) ? op_ext[3:0] : 4'h0;
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                  (op == OP_OR)  || (op == OP_XOR);

`ifdef UC_SINGLE_STEP_EN
  logic step_q;
  logic armed_q, armed_d;

  // An armed step releases one instruction. Once an instruction has left T0, it always completes.
  assign active = RUN || armed_q || (state_q != T0);

  // Arm only from idle T0 on a STEP rising edge. The armed flag clears when the released instruction ends.
  always_comb begin
    armed_d = armed_q;
    if (armed_q) begin
      if (done) armed_d = 1'b0;
    end else if (!RUN && !hlt_q && (state_q == T0) && STEP && !step_q) begin
      armed_d = 1'b1;
    end
  end

  // Step edge detector and release flag.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      step_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      step_q  <= STEP;
      armed_q <= armed_d;
    end
  end
`else
  logic unused_run_step;
  assign unused_run_step = RUN ^ STEP;
  assign active = 1'b1;
`endif

  // Decode of the control word, the ending state and the next state.
  // While in reset or halted, or while idling for a step, all outputs are held at 0.
  always_comb begin
    {Cp, Ep, Ej, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp} = '0;
    {La, Ea, Lb, Lm, CE, We, L1, Ei, L0, Lf}              = '0;
    done      = 1'b0;
    state_d   = state_q;
    hlt_d     = hlt_q;
    retired_d = retired_q;
    if (CLR_n && !hlt_q && active) begin
      case (state_q)
        T0: begin Ep = 1'b1; Lm = 1'b1; end
        T1: begin CE = 1'b1; L1 = 1'b1; end
        T2: begin
          Cp = 1'b1;
          if (!(is_alu || (op == OP_LDA) || (op == OP_STA) || (op == OP_JMP) ||
                (op == OP_JZ) || (op == OP_JC) || (op == OP_NOT) || (op == OP_OUT)))
            done = 1'b1;
          if (op == OP_HLT) hlt_d = 1'b1;
        end
        T3: begin
          case (op)
            OP_JMP: begin Ei = 1'b1; Ej = 1'b1; done = 1'b1; end
            OP_JZ:  begin Ei = Z; Ej = Z; done = 1'b1; end
            OP_JC:  begin Ei = C; Ej = C; done = 1'b1; end
            OP_NOT: begin Eu = 1'b1; NotOp = 1'b1; La = 1'b1; done = 1'b1; end
            OP_OUT: begin Ea = 1'b1; L0 = 1'b1; done = 1'b1; end
            default: begin
              if (is_alu || (op == OP_LDA) || (op == OP_STA)) begin
                Ei = 1'b1; Lm = 1'b1;
              end else begin
                done = 1'b1;
              end
            end
          endcase
        end
        T4: begin
          if (op == OP_LDA) begin
            CE = 1'b1; La = 1'b1; done = 1'b1;
          end else if (op == OP_STA) begin
            Ea = 1'b1; CE = 1'b1; We = 1'b1; done = 1'b1;
          end else if (is_alu) begin
            CE = 1'b1; Lb = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
        T5: begin
          done = 1'b1;
          if (is_alu) begin
            Eu = 1'b1; La = 1'b1; Lf = 1'b1;
            Add   = (op == OP_ADD);
            Sub   = (op == OP_SUB);
            AndOp = (op == OP_AND);
            OrOp  = (op == OP_OR);
            XorOp = (op == OP_XOR);
          end
        end
        default: state_d = T0;
      endcase
      if (done) begin
        state_d   = T0;
        retired_d = retired_q + 1'b1;
      end else if (state_q != T0 || active) begin
        case (state_q)
          T0: state_d = T1;
          T1: state_d = T2;
          T2: state_d = T3;
          T3: state_d = T4;
          T4: state_d = T5;
          default: state_d = T0;
        endcase
      end
    end
  end

  assign instr_done = done;
  assign t_state    = state_q;
  assign Hlt        = hlt_q;
  assign retired    = retired_q;

  // Sequencer state, halt latch and retired counter.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q   <= T0;
      hlt_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      hlt_q     <= hlt_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_unidade_controle_variavel.sv
// Testbench for unidade_controle_variavel. It keeps a scoreboard of per-cycle expected sequencer outputs.
module tb_unidade_controle_variavel;

  logic        CLK, CLR_n, zf, cf, RUN, STEP;
  logic [3:0]  opcode;
  logic        Cp, Ep, Ej, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp;
  logic        La, Ea, Lb, Lm, CE, We, L1, Ei, L0, Lf;
  logic [2:0]  t_state;
  logic        Hlt, instr_done;
  logic [15:0] retired;
  logic [19:0] ctl_obs;

  localparam logic [19:0] M_CP  = 20'h80000, M_EP  = 20'h40000, M_EJ  = 20'h20000,
                          M_EU  = 20'h10000, M_ADD = 20'h08000, M_SUB = 20'h04000,
                          M_AND = 20'h02000, M_OR  = 20'h01000, M_XOR = 20'h00800,
                          M_NOT = 20'h00400, M_LA  = 20'h00200, M_EA  = 20'h00100,
                          M_LB  = 20'h00080, M_LM  = 20'h00040, M_CE  = 20'h00020,
                          M_WE  = 20'h00010, M_L1  = 20'h00008, M_EI  = 20'h00004,
                          M_L0  = 20'h00002, M_LF  = 20'h00001;

  typedef struct {
    logic [2:0]  t;
    logic [19:0] ctl;
    logic        done;
    logic [15:0] ret;
    logic        hlt;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] ret_m  = '0;

  unidade_controle_variavel #(.OPW(4), .CNTW(16)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .opcode(opcode), .Z(zf), .C(cf), .RUN(RUN), .STEP(STEP),
    .Cp(Cp), .Ep(Ep), .Ej(Ej), .Eu(Eu), .Add(Add), .Sub(Sub), .AndOp(AndOp), .OrOp(OrOp),
    .XorOp(XorOp), .NotOp(NotOp), .La(La), .Ea(Ea), .Lb(Lb), .Lm(Lm), .CE(CE), .We(We),
    .L1(L1), .Ei(Ei), .L0(L0), .Lf(Lf), .t_state(t_state), .Hlt(Hlt),
    .instr_done(instr_done), .retired(retired)
  );

  assign ctl_obs = {Cp, Ep, Ej, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp,
                    La, Ea, Lb, Lm, CE, We, L1, Ei, L0, Lf};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cycles(input logic [3:0] op);
    case (op)
      4'h1, 4'h2:                         return 5;
      4'h4, 4'h5, 4'h6, 4'h7, 4'h8:       return 6;
      4'h9, 4'hA, 4'hB, 4'hC, 4'hE:       return 4;
      default:                            return 3;
    endcase
  endfunction

  function automatic logic [19:0] exp_ctl(input logic [3:0] op, input int t,
                                          input logic z, input logic c);
    logic alu;
    alu = (op >= 4'h4) && (op <= 4'h8);
    case (t)
      0: return M_EP | M_LM;
      1: return M_CE | M_L1;
      2: return M_CP;
      3: begin
        if (op == 4'hA) return M_EI | M_EJ;
        if (op == 4'hB) return z ? (M_EI | M_EJ) : 20'h0;
        if (op == 4'hC) return c ? (M_EI | M_EJ) : 20'h0;
        if (op == 4'h9) return M_EU | M_NOT | M_LA;
        if (op == 4'hE) return M_EA | M_L0;
        if (alu || op == 4'h1 || op == 4'h2) return M_EI | M_LM;
        return 20'h0;
      end
      4: begin
        if (op == 4'h1) return M_CE | M_LA;
        if (op == 4'h2) return M_EA | M_CE | M_WE;
        if (alu) return M_CE | M_LB;
        return 20'h0;
      end
      5: begin
        case (op)
          4'h4: return M_EU | M_ADD | M_LA | M_LF;
          4'h5: return M_EU | M_SUB | M_LA | M_LF;
          4'h6: return M_EU | M_AND | M_LA | M_LF;
          4'h7: return M_EU | M_OR  | M_LA | M_LF;
          4'h8: return M_EU | M_XOR | M_LA | M_LF;
          default: return 20'h0;
        endcase
      end
      default: return 20'h0;
    endcase
  endfunction

  task automatic compare_next();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("t_state", {29'd0, t_state}, {29'd0, e.t});
      chk("ctl", {12'd0, ctl_obs}, {12'd0, e.ctl});
      chk("instr_done", {31'd0, instr_done}, {31'd0, e.done});
      chk("retired", {16'd0, retired}, {16'd0, e.ret});
      chk("hlt", {31'd0, Hlt}, {31'd0, e.hlt});
    end
  endtask

  // Expects to be entered at a sample point with the DUT sitting in an active T0.
  task automatic run_instr(input logic [3:0] op, input logic z, input logic c,
                           input bit tog, input int upto);
    int   n;
    exp_t e;
    n = cycles(op);
    opcode = op; zf = z; cf = c;
    #1;
    for (int k = 0; k < n; k++) begin
      e.t = 3'(k); e.ctl = exp_ctl(op, k, z, c); e.done = (k == n - 1);
      e.ret = ret_m; e.hlt = 1'b0;
      if (k < upto) sbq.push_back(e);
    end
    for (int k = 0; k < n && k < upto; k++) begin
      if (tog && k == 1) STEP = 1'b0;
      if (tog && k == 2) STEP = 1'b1;
      compare_next();
      if (k < upto - 1 || upto >= n) begin
        @(posedge CLK); #1;
      end
    end
    if (upto >= n) ret_m = ret_m + 16'd1;
  endtask

  task automatic check_idle(input string tag, input logic [15:0] ret, input logic hlt);
    chk({tag, "_t"}, {29'd0, t_state}, 32'd0);
    chk({tag, "_ctl"}, {12'd0, ctl_obs}, 32'd0);
    chk({tag, "_done"}, {31'd0, instr_done}, 32'd0);
    chk({tag, "_ret"}, {16'd0, retired}, {16'd0, ret});
    chk({tag, "_hlt"}, {31'd0, Hlt}, {31'd0, hlt});
  endtask

  initial begin
    logic [3:0] prog [16];
    logic       pz   [16];
    logic       pc   [16];
    prog = '{4'h1, 4'h5, 4'hB, 4'hB, 4'hC, 4'hC, 4'hA, 4'h9,
             4'hE, 4'h2, 4'h4, 4'h6, 4'h7, 4'h8, 4'h0, 4'h3};
    pz   = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    pc   = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    CLR_n = 1'b0; RUN = 1'b1; STEP = 1'b0; zf = 1'b0; cf = 1'b0; opcode = 4'h1;
    #3;
    check_idle("reset", 16'd0, 1'b0);
    @(posedge CLK); #1;
    CLR_n = 1'b1;

    for (int i = 0; i < 16; i++) run_instr(prog[i], pz[i], pc[i], 1'b0, 99);

    // Abort an ADD in T4 with an asynchronous reset.
    run_instr(4'h4, 1'b0, 1'b0, 1'b0, 5);
    #2;
    CLR_n = 1'b0;
    #1;
    check_idle("midreset", 16'd0, 1'b0);
    ret_m = '0;
    @(posedge CLK); #1;
    CLR_n = 1'b1;

    // Halt is sticky against opcode and STEP activity until reset.
    run_instr(4'hF, 1'b0, 1'b0, 1'b0, 99);
    for (int i = 0; i < 8; i++) begin
      opcode = 4'($urandom_range(0, 15));
      STEP = ~STEP;
      #1;
      check_idle("halt", 16'd1, 1'b1);
      @(posedge CLK); #1;
    end
    CLR_n = 1'b0;
    #1;
    check_idle("postclr", 16'd0, 1'b0);
    ret_m = '0;
    STEP = 1'b0;
    @(posedge CLK); #1;
    CLR_n = 1'b1;
    run_instr(4'h0, 1'b0, 1'b0, 1'b0, 99);

`ifdef UC_SINGLE_STEP_EN
    RUN = 1'b0; opcode = 4'h4;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_idle("stepidle", ret_m, 1'b0);
      @(posedge CLK); #1;
    end
    STEP = 1'b1;
    #1;
    check_idle("stepedge", ret_m, 1'b0);
    @(posedge CLK); #1;
    run_instr(4'h4, 1'b0, 1'b0, 1'b1, 99);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_idle("stepafter", ret_m, 1'b0);
      @(posedge CLK); #1;
    end
    RUN = 1'b1;
    @(posedge CLK); #1;
    run_instr(4'h1, 1'b0, 1'b0, 1'b0, 99);
`endif

    chk("sb_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
